// File: rtl/limb_ram_pkg.sv
// limb_ram_pkg: shared burst FSM state type and default limb geometry for limb_ram
package limb_ram_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} burst_state_e;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 32;
endpackage

// File: rtl/limb_skid_buf.sv
// limb_skid_buf: 2-entry in-order valid/ready buffer, emptied by reset
module limb_skid_buf #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic         push, pop;
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = e0_q;
  always_comb begin
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    e0_d  = (pop && cnt_q == 2'd2) ? e1_q :
            (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? in_data : e0_q;
    e1_d  = (push && cnt_q == 2'd1 && !pop) ? in_data : e1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
endmodule

// File: rtl/limb_ram.sv
// limb_ram: limb store with random read and wrapping burst stream; LIMB_RAM_BYPASS_EN selects write-first reads
module limb_ram
  import limb_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rden,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] burst_base,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word, fetch_word, data_out_q, data_out_d;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  burst_state_e      state_q, state_d;
  logic              fetch, skid_ready, len_ok;
`ifdef LIMB_RAM_BYPASS_EN
  assign rd_word    = (wren && waddr == raddr) ? data_in : mem[raddr];
  assign fetch_word = (wren && waddr == ptr_q) ? data_in : mem[ptr_q];
`else
  assign rd_word    = mem[raddr];
  assign fetch_word = mem[ptr_q];
`endif
  always_ff @(posedge clock) begin
    if (wren) mem[waddr] <= data_in;
  end
  assign data_out_d = rden ? rd_word : data_out_q;
  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = state_q != IDLE;
  assign len_ok     = burst_len != '0 && burst_len <= MAX_LEN;
  // Random reads own the single read port; the burst only fetches on idle cycles.
  assign fetch      = state_q == RUN && !rden && skid_ready;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (burst_start && len_ok) begin
        state_d = RUN;
        ptr_d   = burst_base;
        rem_d   = burst_len;
      end
      RUN: if (fetch) begin
        ptr_d   = ptr_q + ADDR_W'(1);
        rem_d   = rem_q - (ADDR_W+1)'(1);
        state_d = rem_q == (ADDR_W+1)'(1) ? DRAIN : RUN;
      end
      DRAIN: if (out_valid && out_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rden;
    end
  end
  limb_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (clock),
    .rst       (reset),
    .in_valid  (fetch),
    .in_ready  (skid_ready),
    .in_data   ({rem_q == (ADDR_W+1)'(1), fetch_word}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_last, out_data})
  );
endmodule

// File: tb/tb_limb_ram.sv
// tb_limb_ram: directed self-checking bench for limb_ram
module tb_limb_ram;
  logic        clock = 0, reset = 1;
  logic        wren = 0, rden = 0, burst_start = 0, out_ready = 0;
  logic [4:0]  waddr = 0, raddr = 0, burst_base = 0;
  logic [5:0]  burst_len = 0;
  logic [63:0] data_in = 0;
  logic [63:0] data_out, out_data;
  logic        rd_valid, busy, out_valid, out_last;
  int          n_vec = 0, n_err = 0;
  int          first_hs, last_hs;

  limb_ram dut (
    .clock(clock), .reset(reset), .wren(wren), .waddr(waddr), .data_in(data_in),
    .rden(rden), .raddr(raddr), .data_out(data_out), .rd_valid(rd_valid),
    .burst_start(burst_start), .burst_base(burst_base), .burst_len(burst_len),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    wren = 1; waddr = 5'(a); data_in = d;
    tick();
    wren = 0;
  endtask

  // mode 0: ready high; mode 1: ready pattern 1,0,0,1; mode 2: ready high, rden every other cycle
  task automatic run_burst(input int base, input int len, input int mode,
                           output int first, output int last);
    int k = 0, cyc = 0;
    logic stall = 0, rd_pend = 0, pl = 0;
    logic [63:0] pd = 0;
    logic [4:0] ra = 0;
    logic [3:0] pat = 4'b1001;
    first = -1; last = -1;
    burst_base = 5'(base); burst_len = 6'(len); burst_start = 1; out_ready = 1;
    tick();
    burst_start = 0;
    check("busy_rise", 64'(busy), 64'd1);
    while (k < len && cyc < 200) begin
      out_ready = (mode == 1) ? pat[cyc % 4] : 1'b1;
      if (mode == 2) begin
        rden = (cyc % 2 == 0);
        raddr = 5'(cyc + 3);
      end
      if (rd_pend) begin
        check("burst_rd_data", data_out, 64'(ra));
        check("burst_rd_valid", 64'(rd_valid), 64'd1);
      end
      if (stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_word", {out_last, out_data[62:0]}, {pl, pd[62:0]});
      end
      if (out_valid && out_ready) begin
        check("burst_data", out_data, 64'((base + k) % 32));
        check("burst_last", 64'(out_last), 64'(k == len - 1));
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
      stall = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      rd_pend = rden; ra = raddr;
      tick();
      cyc++;
    end
    rden = 0;
    if (k < len) check("burst_timeout", 64'(k), 64'(len));
    check("busy_fall", 64'(busy), 64'd0);
    if (rd_pend) check("burst_rd_tail", data_out, 64'(ra));
  endtask

  initial begin
    tick(); tick();
    check("rst_data_out", data_out, 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    reset = 0;
    tick();

    wr(5, 64'hDEAD_BEEF_0000_0005);
    rden = 1; raddr = 5;
    tick();
    rden = 0;
    check("rd_data", data_out, 64'hDEAD_BEEF_0000_0005);
    check("rd_valid_pulse", 64'(rd_valid), 64'd1);
    tick();
    check("rd_hold", data_out, 64'hDEAD_BEEF_0000_0005);
    check("rd_valid_low", 64'(rd_valid), 64'd0);

    for (int i = 0; i < 32; i++) wr(i, 64'(i));

    run_burst(30, 4, 0, first_hs, last_hs);
    check("first_latency", 64'(first_hs), 64'd1);
    check("full_rate_span", 64'(last_hs - first_hs), 64'd3);
    run_burst(30, 4, 1, first_hs, last_hs);
    run_burst(10, 8, 2, first_hs, last_hs);
    check("half_rate_span", 64'(last_hs - first_hs), 64'd14);

    wren = 1; waddr = 3; data_in = 64'd7; rden = 1; raddr = 3;
    tick();
    wren = 0; rden = 0;
`ifdef LIMB_RAM_BYPASS_EN
    check("same_cycle_rd", data_out, 64'd7);
`else
    check("same_cycle_rd", data_out, 64'd3);
`endif
    rden = 1;
    tick();
    rden = 0;
    check("after_write_rd", data_out, 64'd7);
    wr(3, 64'd3);

    burst_base = 0; burst_len = 8; burst_start = 1; out_ready = 0;
    tick();
    burst_start = 0;
    tick(); tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_quiet", 64'(out_valid), 64'd0);
    end

    burst_len = 0; burst_start = 1;
    tick();
    burst_start = 0;
    tick();
    check("len0_ignored", 64'(busy), 64'd0);
    burst_len = 33; burst_start = 1;
    tick();
    burst_start = 0;
    tick();
    check("len33_ignored", 64'(busy), 64'd0);

    burst_base = 0; burst_len = 2; burst_start = 1;
    tick();
    burst_base = 20; burst_len = 3;
    tick();
    burst_start = 0;
    check("busy_start_word", out_data, 64'd0);
    check("busy_start_valid", 64'(out_valid), 64'd1);
    tick();
    check("busy_start_word2", out_data, 64'd1);
    check("busy_start_last", 64'(out_last), 64'd1);
    tick();
    check("busy_start_done", 64'(busy), 64'd0);
    tick();
    check("busy_start_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
